// File: rtl/seven_seg_pkg.sv
// Shared definitions for the seven-segment bus controller: register offsets,
// control bit positions and the hex-to-segment decoder.
package seven_seg_pkg;

    localparam int EN_BIT  = 0;
    localparam int RAW_BIT = 1;

    function automatic int ctrl_ofs(input int nr);
        return nr;
    endfunction

    function automatic int dp_ofs(input int nr);
        return nr + 1;
    endfunction

    // Active-high segments, bit 0 = a ... bit 6 = g.
    function automatic logic [6:0] hex7seg(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0:    s = 7'h3F;
            4'h1:    s = 7'h06;
            4'h2:    s = 7'h5B;
            4'h3:    s = 7'h4F;
            4'h4:    s = 7'h66;
            4'h5:    s = 7'h6D;
            4'h6:    s = 7'h7D;
            4'h7:    s = 7'h07;
            4'h8:    s = 7'h7F;
            4'h9:    s = 7'h6F;
            4'hA:    s = 7'h77;
            4'hB:    s = 7'h7C;
            4'hC:    s = 7'h39;
            4'hD:    s = 7'h5E;
            4'hE:    s = 7'h79;
            4'hF:    s = 7'h71;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seven_seg_scan.sv
// Digit scan timing: per-digit slot counter, digit index, free-running PWM
// counter and the "a digit is lit right now" qualifier.
module seven_seg_scan
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic                          en_i,
    input  logic [3:0]                    duty_i,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx_o,
    output logic                          active_o
);

    localparam int IDX_W  = $clog2(NUM_DIGITS);
    localparam int SLOT_W = $clog2(REFRESH_DIV);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [IDX_W-1:0]  idx_q,  idx_d;
    logic [3:0]        pwm_q,  pwm_d;

    always_comb begin
        slot_d = slot_q + SLOT_W'(1);
        idx_d  = idx_q;
        pwm_d  = pwm_q + 4'd1;
        if (slot_q == SLOT_LAST) begin
            slot_d = {SLOT_W{1'b0}};
            idx_d  = (idx_q == IDX_LAST) ? {IDX_W{1'b0}} : idx_q + IDX_W'(1);
        end else begin
            slot_d = slot_q + SLOT_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            slot_q <= {SLOT_W{1'b0}};
            idx_q  <= {IDX_W{1'b0}};
            pwm_q  <= 4'd0;
        end else begin
            slot_q <= slot_d;
            idx_q  <= idx_d;
            pwm_q  <= pwm_d;
        end
    end

    // DUTY=0 never lights; DUTY=15 lights for pwm 0..14.
    assign digit_idx_o = idx_q;
    assign active_o    = en_i && (pwm_q < duty_i);

endmodule

// File: rtl/seven_seg_bus_ctrl.sv
// Memory-mapped multiplexed seven-segment controller: bus register file,
// zero-wait-state tri-state read port and registered segment/anode outputs.
module seven_seg_bus_ctrl
    import seven_seg_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR   = 8'hD0,
    parameter int         NUM_DIGITS  = 4,
    parameter int         REFRESH_DIV = 50000,
    parameter logic [7:0] CTRL_RESET  = 8'hF1
) (
    input  logic                  CLK,
    input  logic                  RESET,
    inout  wire  [7:0]            BUS_DATA,
    input  logic [7:0]            BUS_ADDR,
    input  logic                  BUS_WE,
    output logic [6:0]            SEG_N,
    output logic                  DP_N,
    output logic [NUM_DIGITS-1:0] AN_N
);

    localparam int NR    = NUM_DIGITS / 2;
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [7:0] CTRL_OFS8 = 8'(ctrl_ofs(NR));
    localparam logic [7:0] DP_OFS8   = 8'(dp_ofs(NR));
    localparam logic [NUM_DIGITS-1:0] AN_ONE = {{(NUM_DIGITS-1){1'b0}}, 1'b1};

    if ((NUM_DIGITS % 2) != 0 || NUM_DIGITS < 2 || NUM_DIGITS > 8) begin : g_bad_digits
        $error("seven_seg_bus_ctrl: NUM_DIGITS must be even and in 2..8");
    end
    if (REFRESH_DIV < 16) begin : g_bad_div
        $error("seven_seg_bus_ctrl: REFRESH_DIV must be >= 16");
    end
    if (int'(BASE_ADDR) + NR + 1 > 255) begin : g_bad_base
        $error("seven_seg_bus_ctrl: register map runs past 8'hFF");
    end

    logic [7:0]            data_q [NR];
    logic [7:0]            ctrl_q;
    logic [NUM_DIGITS-1:0] dp_q;
    logic [7:0]            ofs_s, rd_data_s, pair_byte_s;
    logic                  in_map_s, wr_s, rd_en_s, active_s;
    logic [IDX_W-1:0]      idx_s;
    logic [3:0]            nibble_s;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q_out, dp_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;

    assign ofs_s    = BUS_ADDR - BASE_ADDR;
    assign in_map_s = (BUS_ADDR >= BASE_ADDR) && (ofs_s <= DP_OFS8);
    assign wr_s     = BUS_WE && in_map_s;
    assign rd_en_s  = !BUS_WE && in_map_s;

    // Register file write port; control bits [3:2] are masked to zero.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < NR; i++) data_q[i] <= 8'h00;
            ctrl_q <= CTRL_RESET & 8'hF3;
            dp_q   <= {NUM_DIGITS{1'b0}};
        end else if (wr_s) begin
            for (int i = 0; i < NR; i++) begin
                if (ofs_s == 8'(i)) data_q[i] <= BUS_DATA;
            end
            if (ofs_s == CTRL_OFS8) ctrl_q <= BUS_DATA & 8'hF3;
            if (ofs_s == DP_OFS8)   dp_q   <= BUS_DATA[NUM_DIGITS-1:0];
        end
    end

    always_comb begin
        rd_data_s = 8'h00;
        for (int i = 0; i < NR; i++) begin
            rd_data_s = (ofs_s == 8'(i)) ? data_q[i] : rd_data_s;
        end
        rd_data_s = (ofs_s == CTRL_OFS8) ? ctrl_q : rd_data_s;
        rd_data_s = (ofs_s == DP_OFS8) ? 8'(dp_q) : rd_data_s;
    end

    assign BUS_DATA = rd_en_s ? rd_data_s : 8'hZZ;

    seven_seg_scan #(
        .NUM_DIGITS  (NUM_DIGITS),
        .REFRESH_DIV (REFRESH_DIV)
    ) u_scan (
        .CLK         (CLK),
        .RESET       (RESET),
        .en_i        (ctrl_q[EN_BIT]),
        .duty_i      (ctrl_q[7:4]),
        .digit_idx_o (idx_s),
        .active_o    (active_s)
    );

    always_comb begin
        pair_byte_s = 8'h00;
        for (int i = 0; i < NR; i++) begin
            pair_byte_s = ((int'(idx_s) / 2) == i) ? data_q[i] : pair_byte_s;
        end
    end

    assign nibble_s = idx_s[0] ? pair_byte_s[7:4] : pair_byte_s[3:0];

    always_comb begin
        seg_d = 7'h7F;
        dp_d  = 1'b1;
        an_d  = {NUM_DIGITS{1'b1}};
        if (active_s) begin
            an_d  = ~(AN_ONE << idx_s);
            seg_d = ctrl_q[RAW_BIT] ? ~pair_byte_s[6:0] : ~hex7seg(nibble_s);
            dp_d  = ~dp_q[idx_s];
        end else begin
            an_d  = {NUM_DIGITS{1'b1}};
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            seg_q    <= 7'h7F;
            dp_q_out <= 1'b1;
            an_q     <= {NUM_DIGITS{1'b1}};
        end else begin
            seg_q    <= seg_d;
            dp_q_out <= dp_d;
            an_q     <= an_d;
        end
    end

    assign SEG_N = seg_q;
    assign DP_N  = dp_q_out;
    assign AN_N  = an_q;

endmodule

// File: tb/tb_seven_seg_bus_ctrl.sv
// Directed bench: a 4-digit and an 8-digit controller, both with a 16-cycle slot.
module tb_seven_seg_bus_ctrl;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_fail = 0;

    // 4-digit instance at 8'hD0
    wire  [7:0] bus_a;
    logic [7:0] addr_a = 8'h00, drv_a = 8'h00;
    logic       we_a = 1'b0, oe_a = 1'b0;
    logic [6:0] seg_a;
    logic       dp_a;
    logic [3:0] an_a;
    assign bus_a = oe_a ? drv_a : 8'hZZ;

    // 8-digit instance at 8'h80
    wire  [7:0] bus_b;
    logic [7:0] addr_b = 8'h00, drv_b = 8'h00;
    logic       we_b = 1'b0, oe_b = 1'b0;
    logic [6:0] seg_b;
    logic       dp_b;
    logic [7:0] an_b;
    assign bus_b = oe_b ? drv_b : 8'hZZ;

    seven_seg_bus_ctrl #(.BASE_ADDR(8'hD0), .NUM_DIGITS(4), .REFRESH_DIV(16), .CTRL_RESET(8'hF1)) dut_a (
        .CLK(CLK), .RESET(RESET), .BUS_DATA(bus_a), .BUS_ADDR(addr_a), .BUS_WE(we_a),
        .SEG_N(seg_a), .DP_N(dp_a), .AN_N(an_a));

    seven_seg_bus_ctrl #(.BASE_ADDR(8'h80), .NUM_DIGITS(8), .REFRESH_DIV(16), .CTRL_RESET(8'hF1)) dut_b (
        .CLK(CLK), .RESET(RESET), .BUS_DATA(bus_b), .BUS_ADDR(addr_b), .BUS_WE(we_b),
        .SEG_N(seg_b), .DP_N(dp_b), .AN_N(an_b));

    always #5 CLK = ~CLK;

    // cyc = number of rising edges since RESET was released
    always @(posedge CLK) begin
        if (RESET) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to the falling edge where cyc == k; outputs then reflect counter state k-1.
    task automatic goto(input int k);
        if (cyc > k) begin
            n_cmp++;
            n_fail++;
            $display("FAIL goto: already at cycle %0d, wanted %0d", cyc, k);
        end
        while (cyc < k) @(negedge CLK);
    endtask

    task automatic wr_a(input logic [7:0] a, input logic [7:0] d);
        @(negedge CLK);
        addr_a = a; drv_a = d; oe_a = 1'b1; we_a = 1'b1;
        @(negedge CLK);
        we_a = 1'b0; oe_a = 1'b0;
    endtask

    task automatic rd_a(input string tag, input logic [7:0] a, input logic [7:0] exp);
        @(negedge CLK);
        addr_a = a; we_a = 1'b0; oe_a = 1'b0;
        #1;
        check(tag, bus_a, exp);
    endtask

    task automatic wr_b(input logic [7:0] a, input logic [7:0] d);
        @(negedge CLK);
        addr_b = a; drv_b = d; oe_b = 1'b1; we_b = 1'b1;
        @(negedge CLK);
        we_b = 1'b0; oe_b = 1'b0;
    endtask

    task automatic rd_b(input string tag, input logic [7:0] a, input logic [7:0] exp);
        @(negedge CLK);
        addr_b = a; we_b = 1'b0; oe_b = 1'b0;
        #1;
        check(tag, bus_b, exp);
    endtask

    initial begin
        int lit;
        logic [7:0] an_b_exp [8];
        logic [7:0] dp_b_exp [8];
        logic [7:0] seg_b_exp [8];
        an_b_exp  = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
        dp_b_exp  = '{8'h01, 8'h00, 8'h01, 8'h00, 8'h01, 8'h00, 8'h01, 8'h00};
        seg_b_exp = '{8'h40, 8'h79, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40};

        // Reset state
        repeat (3) @(negedge CLK);
        check("rst_an", {4'h0, an_a}, 8'h0F);
        check("rst_seg", {1'b0, seg_a}, 8'h7F);
        check("rst_dp", {7'h00, dp_a}, 8'h01);
        RESET = 1'b0;
        rd_a("rd_d0_def", 8'hD0, 8'h00);
        rd_a("rd_d1_def", 8'hD1, 8'h00);
        rd_a("rd_d2_def", 8'hD2, 8'hF1);
        rd_a("rd_d3_def", 8'hD3, 8'h00);

        // Digits 1,2,3,4 at DUTY=15
        wr_a(8'hD0, 8'h21);
        wr_a(8'hD1, 8'h43);
        goto(67);  check("an_d0", {4'h0, an_a}, 8'h0E); check("seg_d0", {1'b0, seg_a}, 8'h79);
        goto(80);  check("an_slot15", {4'h0, an_a}, 8'h0F); check("seg_slot15", {1'b0, seg_a}, 8'h7F);
        goto(83);  check("an_d1", {4'h0, an_a}, 8'h0D); check("seg_d1", {1'b0, seg_a}, 8'h24);
        goto(99);  check("an_d2", {4'h0, an_a}, 8'h0B); check("seg_d2", {1'b0, seg_a}, 8'h30);
        goto(115); check("an_d3", {4'h0, an_a}, 8'h07); check("seg_d3", {1'b0, seg_a}, 8'h19);
        check("dp_off", {7'h00, dp_a}, 8'h01);
        goto(131); check("an_wrap", {4'h0, an_a}, 8'h0E); check("seg_wrap", {1'b0, seg_a}, 8'h79);

        // DUTY=3: lit 3 of 16 cycles
        wr_a(8'hD2, 8'h31);
        lit = 0;
        for (int k = 145; k <= 160; k++) begin
            goto(k);
            if (an_a != 4'hF) lit++;
        end
        check("duty3_count", 8'(lit), 8'd3);
        goto(163); check("duty3_on", {4'h0, an_a}, 8'h0B);
        goto(164); check("duty3_off", {4'h0, an_a}, 8'h0F);

        // DUTY=0: dark
        wr_a(8'hD2, 8'h01);
        lit = 0;
        for (int k = 177; k <= 192; k++) begin
            goto(k);
            if (an_a != 4'hF) lit++;
        end
        check("duty0_count", 8'(lit), 8'd0);

        // EN=0 then back on: scan must have kept advancing
        wr_a(8'hD2, 8'h00);
        goto(211); check("en_off", {4'h0, an_a}, 8'h0F);
        wr_a(8'hD2, 8'hF1);
        goto(227); check("en_back_an", {4'h0, an_a}, 8'h0B); check("en_back_seg", {1'b0, seg_a}, 8'h30);

        // Decimal points and read port
        wr_a(8'hD3, 8'h05);
        rd_a("rd_dp", 8'hD3, 8'h05);
        @(negedge CLK);
        addr_a = 8'hD4; we_a = 1'b0; drv_a = 8'hA5; oe_a = 1'b1;
        #1;
        check("rd_unmapped_nodrive", bus_a, 8'hA5);
        oe_a = 1'b0;
        goto(259); check("dp_d0", {7'h00, dp_a}, 8'h00); check("dp_d0_an", {4'h0, an_a}, 8'h0E);
        goto(275); check("dp_d1", {7'h00, dp_a}, 8'h01);
        goto(291); check("dp_d2", {7'h00, dp_a}, 8'h00);
        goto(292); check("dp_d2_late", {7'h00, dp_a}, 8'h00);
        goto(320); check("dp_dark", {7'h00, dp_a}, 8'h01);

        // Reset mid-slot on digit 2
        goto(358); check("pre_rst_an", {4'h0, an_a}, 8'h0B);
        RESET = 1'b1;
        @(negedge CLK);
        check("midrst_an", {4'h0, an_a}, 8'h0F);
        check("midrst_seg", {1'b0, seg_a}, 8'h7F);
        check("midrst_dp", {7'h00, dp_a}, 8'h01);
        rd_a("midrst_d0", 8'hD0, 8'h00);
        rd_a("midrst_ctrl", 8'hD2, 8'hF1);
        RESET = 1'b0;
        goto(3);  check("restart_an", {4'h0, an_a}, 8'h0E); check("restart_seg", {1'b0, seg_a}, 8'h40);
        goto(16); check("restart_dark", {4'h0, an_a}, 8'h0F);
        goto(19); check("restart_d1", {4'h0, an_a}, 8'h0D);

        // 8-digit instance at 8'h80
        wr_b(8'h80, 8'h10);
        wr_b(8'hD0, 8'h12);
        wr_b(8'h85, 8'hAA);
        rd_b("b_rd_d0", 8'h80, 8'h10);
        rd_b("b_rd_d1", 8'h81, 8'h00);
        rd_b("b_rd_ctrl", 8'h84, 8'hF1);
        rd_b("b_rd_dp", 8'h85, 8'hAA);
        @(negedge CLK);
        addr_b = 8'hD0; we_b = 1'b0; drv_b = 8'h5A; oe_b = 1'b1;
        #1;
        check("b_rd_d0addr_nodrive", bus_b, 8'h5A);
        oe_b = 1'b0;
        for (int d = 0; d < 8; d++) begin
            goto(16 * (8 + d) + 3);
            check($sformatf("b_an_d%0d", d), an_b, an_b_exp[d]);
            check($sformatf("b_dp_d%0d", d), {7'h00, dp_b}, dp_b_exp[d]);
            check($sformatf("b_seg_d%0d", d), {1'b0, seg_b}, seg_b_exp[d]);
        end

        // RAW mode: byte 8'h10 drives segments directly on both digits of pair 0
        wr_b(8'h84, 8'hF3);
        rd_b("b_rd_raw_ctrl", 8'h84, 8'hF3);
        goto(259); check("b_raw_an0", an_b, 8'hFE); check("b_raw_seg0", {1'b0, seg_b}, 8'h6F);
        goto(275); check("b_raw_seg1", {1'b0, seg_b}, 8'h6F); check("b_raw_dp1", {7'h00, dp_b}, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
